fp_add_seq: RTL and testbench

//  Multi-cycle IEEE-754 binary32 adder/subtractor with valid/ready handshakes on both sides.
//  It is the registered, flow-controlled counterpart of the combinational floating unit.
//  It sits between an operand producer (sequencer or CPU datapath) and a result consumer.

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_add_seq_if.sv | 37 +++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_add_seq.sv | 257 +++++++++++++++++++++++++
 tb/tb_fp_add_seq.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared widths, IEEE-754 binary32 constants, FSM encoding and flag bit positions
// for the sequential floating-point adder.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } fsm_t;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

endpackage

// File: rtl/fp_add_seq_if.sv
// Operand/result handshake bundle for fp_add_seq; the flags field exists only
// when FP_FLAGS_EN is defined.
interface fp_add_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
`ifdef FP_FLAGS_EN
    logic [3:0]  flags;

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, flags
    );

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, flags
    );
`else
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result
    );

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result
    );
`endif

endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over the 27-bit sum mantissa; an all-zero
// input reports 27.
module fp_lzc (
    input  logic [26:0] value_i,
    output logic [4:0]  count_o
);

    // Scanning upwards lets the highest set bit overwrite any lower one.
    always_comb begin
        count_o = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (value_i[i]) begin
                count_o = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle binary32 adder/subtractor, IDLE-ALIGN-ADD-NORM-ROUND-DONE, one op in flight.
// Defining FP_FLAGS_EN adds the registered {invalid,overflow,underflow,inexact} flags port.
module fp_add_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic        clk,
    input  logic        rst,
    fp_add_seq_if.slave bus
);

    fsm_t        stateQ, stateD;
    logic [31:0] aQ, aD, bQ, bD;
    logic        signQ, signD, effSubQ, effSubD;
    logic        specialQ, specialD, zeroQ, zeroD;
    logic [9:0]  expQ, expD;
    logic [26:0] mBigQ, mBigD, mSmallQ, mSmallD, mNormQ, mNormD;
    logic [27:0] sumQ, sumD;
    logic [31:0] specialValQ, specialValD, resultQ, resultD;
`ifdef FP_FLAGS_EN
    logic        invalidQ, invalidD;
    logic [3:0]  flagsQ, flagsD;
    logic        invalidHit;
`endif

    logic [7:0]  expA, expB, effExpA, effExpB, bigExp, smallExp, expDiff;
    logic [22:0] fracA, fracB, bigFrac, smallFrac;
    logic        aBig, bigHid, smallHid;
    logic        aNan, bNan, aInf, bInf;
    logic [26:0] small27, alignedSmall;
    logic        specialHit;
    logic [31:0] specialVal;
    logic [4:0]  lzCount, normShift;
    logic [9:0]  maxShift, expRounded;
    logic        roundUp;
    logic [24:0] mantRounded;
    logic [23:0] mantOut;
    logic [31:0] roundedWord;

    assign expA  = aQ[MAN_W +: EXP_W];
    assign expB  = bQ[MAN_W +: EXP_W];
    assign fracA = aQ[MAN_W-1:0];
    assign fracB = bQ[MAN_W-1:0];
    assign aNan  = (&expA) && (|fracA);
    assign bNan  = (&expB) && (|fracB);
    assign aInf  = (&expA) && !(|fracA);
    assign bInf  = (&expB) && !(|fracB);

    // Denormals behave as exponent 1 without the hidden bit; magnitude order of
    // the raw bit patterns decides which operand is the larger.
    always_comb begin
        effExpA   = (expA == 8'd0) ? 8'd1 : expA;
        effExpB   = (expB == 8'd0) ? 8'd1 : expB;
        aBig      = aQ[30:0] >= bQ[30:0];
        bigExp    = aBig ? effExpA : effExpB;
        smallExp  = aBig ? effExpB : effExpA;
        bigFrac   = aBig ? fracA : fracB;
        smallFrac = aBig ? fracB : fracA;
        bigHid    = aBig ? (|expA) : (|expB);
        smallHid  = aBig ? (|expB) : (|expA);
        expDiff   = bigExp - smallExp;
        small27   = {smallHid, smallFrac, 3'd0};
        if (expDiff >= 8'd27) begin
            alignedSmall = {26'd0, |small27};
        end else begin
            alignedSmall = (small27 >> expDiff)
                         | {26'd0, |(small27 & ~(27'h7FF_FFFF << expDiff))};
        end
    end

    always_comb begin
        specialHit = 1'b1;
        specialVal = QNAN;
        if (aNan) begin
            specialVal = aQ | 32'h0040_0000;
        end else if (bNan) begin
            specialVal = bQ | 32'h0040_0000;
        end else if (aInf && bInf && (aQ[31] != bQ[31])) begin
            specialVal = QNAN;
        end else if (aInf) begin
            specialVal = aQ;
        end else if (bInf) begin
            specialVal = bQ;
        end else begin
            specialHit = 1'b0;
        end
    end

`ifdef FP_FLAGS_EN
    assign invalidHit = (aNan && !aQ[22]) || (bNan && !bQ[22])
                      || (aInf && bInf && (aQ[31] != bQ[31]));
`endif

    fp_lzc u_lzc (
        .value_i (sumQ[26:0]),
        .count_o (lzCount)
    );

    // Left shift stops once the exponent reaches 1, leaving a denormal result.
    always_comb begin
        maxShift  = expQ - 10'd1;
        normShift = ({5'd0, lzCount} < maxShift) ? lzCount : maxShift[4:0];
    end

    always_comb begin
        roundUp     = mNormQ[2] && (mNormQ[1] || mNormQ[0] || mNormQ[3]);
        mantRounded = {1'b0, mNormQ[26:3]} + {24'd0, roundUp};
        if (mantRounded[24]) begin
            mantOut    = mantRounded[24:1];
            expRounded = expQ + 10'd1;
        end else begin
            mantOut    = mantRounded[23:0];
            expRounded = expQ;
        end
        if (specialQ) begin
            roundedWord = specialValQ;
        end else if (zeroQ) begin
            roundedWord = {signQ && !effSubQ, 31'd0};
        end else if (expRounded >= 10'd255) begin
            roundedWord = {signQ, POS_INF[30:0]};
        end else begin
            roundedWord = {signQ, mantOut[23] ? expRounded[7:0] : 8'd0, mantOut[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (bus.in_valid) stateD = ALIGN;
            ALIGN:   stateD = ADD;
            ADD:     stateD = NORM;
            NORM:    stateD = ROUND;
            ROUND:   stateD = DONE;
            DONE:    if (bus.out_ready) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_comb begin
        aD          = aQ;
        bD          = bQ;
        signD       = signQ;
        effSubD     = effSubQ;
        specialD    = specialQ;
        specialValD = specialValQ;
        zeroD       = zeroQ;
        expD        = expQ;
        mBigD       = mBigQ;
        mSmallD     = mSmallQ;
        mNormD      = mNormQ;
        sumD        = sumQ;
        resultD     = resultQ;
`ifdef FP_FLAGS_EN
        invalidD    = invalidQ;
        flagsD      = flagsQ;
`endif
        case (stateQ)
            IDLE: begin
                if (bus.in_valid) begin
                    aD = bus.a;
                    bD = bus.b ^ {bus.sub, 31'd0};
                end
            end
            ALIGN: begin
                signD       = aBig ? aQ[31] : bQ[31];
                effSubD     = aQ[31] ^ bQ[31];
                expD        = {2'd0, bigExp};
                mBigD       = {bigHid, bigFrac, 3'd0};
                mSmallD     = alignedSmall;
                specialD    = specialHit;
                specialValD = specialVal;
`ifdef FP_FLAGS_EN
                invalidD    = invalidHit;
`endif
            end
            ADD: begin
                sumD = effSubQ ? ({1'b0, mBigQ} - {1'b0, mSmallQ})
                               : ({1'b0, mBigQ} + {1'b0, mSmallQ});
            end
            NORM: begin
                zeroD = (sumQ == 28'd0);
                if (sumQ[27]) begin
                    mNormD = {sumQ[27:2], sumQ[1] | sumQ[0]};
                    expD   = expQ + 10'd1;
                end else begin
                    mNormD = sumQ[26:0] << normShift;
                    expD   = expQ - {5'd0, normShift};
                end
            end
            ROUND: begin
                resultD = roundedWord;
`ifdef FP_FLAGS_EN
                flagsD  = 4'd0;
                if (specialQ) begin
                    flagsD[FLAG_INVALID] = invalidQ;
                end else if (!zeroQ) begin
                    flagsD[FLAG_OVERFLOW]  = expRounded >= 10'd255;
                    flagsD[FLAG_INEXACT]   = (|mNormQ[2:0]) || (expRounded >= 10'd255);
                    flagsD[FLAG_UNDERFLOW] = !mNormQ[26] && (|mNormQ[2:0]);
                end
`endif
            end
            default: ;
        endcase
    end

    // Datapath registers need no reset: every stage rewrites what it consumes.
    always_ff @(posedge clk) begin
        aQ          <= aD;
        bQ          <= bD;
        signQ       <= signD;
        effSubQ     <= effSubD;
        specialQ    <= specialD;
        specialValQ <= specialValD;
        zeroQ       <= zeroD;
        expQ        <= expD;
        mBigQ       <= mBigD;
        mSmallQ     <= mSmallD;
        mNormQ      <= mNormD;
        sumQ        <= sumD;
`ifdef FP_FLAGS_EN
        invalidQ    <= invalidD;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resultQ <= 32'd0;
`ifdef FP_FLAGS_EN
            flagsQ  <= 4'd0;
`endif
        end else begin
            resultQ <= resultD;
`ifdef FP_FLAGS_EN
            flagsQ  <= flagsD;
`endif
        end
    end

    assign bus.in_ready  = (stateQ == IDLE);
    assign bus.out_valid = (stateQ == DONE);
    assign bus.result    = resultQ;
`ifdef FP_FLAGS_EN
    assign bus.flags     = flagsQ;
`endif

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed-vector bench for fp_add_seq: table of hand-computed sums plus
// handshake, throughput and mid-operation reset sequences.
module tb_fp_add_seq;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] expRes;
        logic [3:0]  expFlags;
    } vecT;

    localparam int NUM_VECS = 18;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    vecT  vecs [NUM_VECS];

    fp_add_seq_if bus ();

    fp_add_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int guard = 0;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("accept_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // The accepting edge counts as edge 1; out_valid is due after edge 5.
    task automatic waitOutValid(output int edges);
        edges = 1;
        while (!bus.out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int gap;
        int badCycles;

        vecs[0]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 32'h407FFFFF, 4'h0};
        vecs[1]  = '{32'hBFFFFFFF, 32'h3FFFFFFF, 1'b0, 32'h00000000, 4'h0};
        vecs[2]  = '{32'h000002CA, 32'h000002CA, 1'b0, 32'h00000594, 4'h0};
        vecs[3]  = '{32'h007FFFFF, 32'h00FFFFFF, 1'b0, 32'h013FFFFF, 4'h0};
        vecs[4]  = '{32'hC2F63EFA, 32'h3F8E38E4, 1'b0, 32'hC2F40616, 4'h1};
        vecs[5]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1, 32'h00000000, 4'h0};
        vecs[6]  = '{32'h7F800000, 32'h42F60000, 1'b0, 32'h7F800000, 4'h0};
        vecs[7]  = '{32'hFF800000, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 4'h0};
        vecs[8]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8};
        vecs[9]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5};
        vecs[10] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0};
        vecs[11] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1};
        vecs[12] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1};
        vecs[13] = '{32'h00000000, 32'h00000001, 1'b0, 32'h00000001, 4'h0};
        vecs[14] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0};
        vecs[15] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00001, 4'h8};
        vecs[16] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'h0};
        vecs[17] = '{32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'h1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.sub       = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
        checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset_result",    bus.result,             32'd0);
`ifdef FP_FLAGS_EN
        checkOutput("reset_flags",     {28'd0, bus.flags},     32'd0);
`endif

        bus.out_ready = 1'b1;
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub);
            waitOutValid(lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, 32'd5);
            checkOutput($sformatf("vec%0d_result", i), bus.result, vecs[i].expRes);
`ifdef FP_FLAGS_EN
            checkOutput($sformatf("vec%0d_flags", i), {28'd0, bus.flags}, {28'd0, vecs[i].expFlags});
`endif
        end
        @(negedge clk);

        // Consumer stalls for ten cycles, then releases the result.
        bus.out_ready = 1'b0;
        applyStimulus(32'h40400000, 32'h3F800000, 1'b0);
        waitOutValid(lat);
        checkOutput("hold_latency", lat, 32'd5);
        checkOutput("hold_result", bus.result, 32'h40800000);
        badCycles = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'h40800000)
                badCycles++;
        end
        checkOutput("hold_stable_cycles_bad", badCycles, 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready",  {31'd0, bus.in_ready},  32'd1);
        checkOutput("release_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // in_valid held high with changing operands: the in-flight op keeps its
        // operands, and the second op follows six edges after the first result.
        bus.a        = 32'h3F800000;
        bus.b        = 32'h3F800000;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.a = 32'h40400000;
        bus.b = 32'h40000000;
        waitOutValid(lat);
        checkOutput("b2b_first_latency", lat, 32'd5);
        checkOutput("b2b_first_result", bus.result, 32'h40000000);
        @(negedge clk);
        gap = 1;
        @(negedge clk);
        gap++;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        checkOutput("b2b_result_spacing", gap, 32'd6);
        checkOutput("b2b_second_result", bus.result, 32'h40A00000);
        @(negedge clk);

        // Reset lands while the operation sits in ADD.
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("midreset_in_ready",  {31'd0, bus.in_ready},  32'd1);
        checkOutput("midreset_result",    bus.result,             32'd0);
        repeat (6) @(negedge clk);
        checkOutput("midreset_dropped", {31'd0, bus.out_valid}, 32'd0);

        applyStimulus(32'hC0400000, 32'h3F800000, 1'b1);
        waitOutValid(lat);
        checkOutput("recover_latency", lat, 32'd5);
        checkOutput("recover_result", bus.result, 32'hC0800000);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
